// File: rtl/cdda_pkg.sv
// cdda_pkg
// Shared definitions for the CDDA interface window: register offsets, the
// buffer-window select bit, per-byte slot encodings, the refill DMA state
// enum and a helper that builds a buffer byte address.
package cdda_pkg;

  // Register offsets inside the CDDA register window
  localparam logic [10:0] CDDA_REG_CTRL    = 11'h000;
  localparam logic [10:0] CDDA_REG_POS     = 11'h001;
  localparam logic [10:0] CDDA_REG_LVD     = 11'h002;
  localparam logic [10:0] CDDA_REG_SCRATCH = 11'h003;

  // Address bit that selects the sample buffer instead of the registers
  localparam int CDDA_BUF_SEL = 10;

  // Byte-select encodings within one stereo frame slot (bytes are swapped
  // within each 16-bit channel word)
  localparam logic [1:0] CDDA_LLO = 2'b01;
  localparam logic [1:0] CDDA_LHI = 2'b00;
  localparam logic [1:0] CDDA_RLO = 2'b11;
  localparam logic [1:0] CDDA_RHI = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RDPOS   = 3'd1,
    ST_WR0     = 3'd2,
    ST_WR1     = 3'd3,
    ST_WR2     = 3'd4,
    ST_WR3     = 3'd5,
    ST_PUBLISH = 3'd6,
    ST_WAIT    = 3'd7
  } cdda_state_e;

  // Buffer byte address for frame slot 'slot', byte select 'sel'
  function automatic logic [10:0] cdda_buf_addr(input logic [7:0] slot,
                                                input logic [1:0] sel);
    logic [10:0] a;
    a = {1'b0, slot, sel};
    a[CDDA_BUF_SEL] = 1'b1;
    return a;
  endfunction

endpackage

// File: rtl/cdda_refill_dma.sv
// cdda_refill_dma
// Bus master + arbiter that refills the CDDA sample ring buffer from a byte
// stream. The CPU always wins the single downstream bus; the DMA polls the
// play position, writes whole stereo frames into free slots and publishes
// each frame by writing the slot number to the last-valid register.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   cpu_a/d_in/d_out       CPU SRAM-style bus (cs/oe/we strobes, wait = 0)
//   cdda_a/d_out/d_in      downstream bus to the CDDA window (cs/oe/we)
//   src_data/valid/ready   sample byte stream, L-lo, L-hi, R-lo, R-hi
//   enable                 DMA run request
//   resync                 pulse: rebase write pointer at next position poll
//   wr_pos                 next slot to fill
//   busy                   DMA state machine is active
module cdda_refill_dma
  import cdda_pkg::*;
#(
  parameter int POLL_INTERVAL = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [10:0] cpu_a,
  input  logic [7:0]  cpu_d_in,
  output logic [7:0]  cpu_d_out,
  input  logic        cpu_cs,
  input  logic        cpu_oe,
  input  logic        cpu_we,
  output logic        cpu_wait,
  output logic [10:0] cdda_a,
  output logic [7:0]  cdda_d_out,
  input  logic [7:0]  cdda_d_in,
  output logic        cdda_cs,
  output logic        cdda_oe,
  output logic        cdda_we,
  input  logic [7:0]  src_data,
  input  logic        src_valid,
  output logic        src_ready,
  input  logic        enable,
  input  logic        resync,
  output logic [7:0]  wr_pos,
  output logic        busy
);

  localparam logic [7:0] POLL_LAST = 8'(POLL_INTERVAL - 1);

  cdda_state_e state_r;
  logic [7:0]  wr_pos_r;
  logic [7:0]  poll_cnt_r;
  logic        resync_pend_r;
  logic        busy_r;

  logic        grant_s;
  logic        in_wr_s;
  logic        xfer_s;
  logic [7:0]  rebase_s;
  logic        dma_cs_s;
  logic        dma_oe_s;
  logic        dma_we_s;
  logic [10:0] dma_a_s;
  logic [7:0]  dma_d_s;

  // The DMA owns the bus only in cycles where the CPU is not selecting
  assign grant_s = ~cpu_cs;
  assign xfer_s  = src_valid & grant_s;

  // Downstream access the DMA wants to perform in its current state
  always_comb begin
    dma_cs_s = 1'b0;
    dma_oe_s = 1'b0;
    dma_we_s = 1'b0;
    dma_a_s  = 11'h000;
    dma_d_s  = 8'h00;
    in_wr_s  = 1'b0;
    case (state_r)
      ST_RDPOS: begin
        dma_cs_s = 1'b1;
        dma_oe_s = 1'b1;
        dma_a_s  = CDDA_REG_POS;
      end
      ST_WR0: begin
        in_wr_s  = 1'b1;
        dma_cs_s = src_valid;
        dma_we_s = src_valid;
        dma_a_s  = cdda_buf_addr(wr_pos_r, CDDA_LLO);
        dma_d_s  = src_data;
      end
      ST_WR1: begin
        in_wr_s  = 1'b1;
        dma_cs_s = src_valid;
        dma_we_s = src_valid;
        dma_a_s  = cdda_buf_addr(wr_pos_r, CDDA_LHI);
        dma_d_s  = src_data;
      end
      ST_WR2: begin
        in_wr_s  = 1'b1;
        dma_cs_s = src_valid;
        dma_we_s = src_valid;
        dma_a_s  = cdda_buf_addr(wr_pos_r, CDDA_RLO);
        dma_d_s  = src_data;
      end
      ST_WR3: begin
        in_wr_s  = 1'b1;
        dma_cs_s = src_valid;
        dma_we_s = src_valid;
        dma_a_s  = cdda_buf_addr(wr_pos_r, CDDA_RHI);
        dma_d_s  = src_data;
      end
      ST_PUBLISH: begin
        dma_cs_s = 1'b1;
        dma_we_s = 1'b1;
        dma_a_s  = CDDA_REG_LVD;
        dma_d_s  = wr_pos_r;
      end
      default: begin
        dma_cs_s = 1'b0;
      end
    endcase
  end

  // Bus arbiter: CPU passes straight through whenever it is selecting
  always_comb begin
    cpu_d_out = cdda_d_in;
    if (cpu_cs) begin
      cdda_cs    = 1'b1;
      cdda_oe    = cpu_oe;
      cdda_we    = cpu_we;
      cdda_a     = cpu_a;
      cdda_d_out = cpu_d_in;
    end else begin
      cdda_cs    = dma_cs_s;
      cdda_oe    = dma_oe_s;
      cdda_we    = dma_we_s;
      cdda_a     = dma_a_s;
      cdda_d_out = dma_d_s;
    end
  end

  // Write pointer after an optional resync rebase onto the polled position
  always_comb begin
    if (resync_pend_r) begin
      rebase_s = cdda_d_in + 8'd1;
    end else begin
      rebase_s = wr_pos_r;
    end
  end

  assign src_ready = in_wr_s & grant_s;
  assign cpu_wait  = 1'b0;
  assign wr_pos    = wr_pos_r;
  assign busy      = busy_r;

  // Refill state machine, write pointer, resync flag and poll counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= ST_IDLE;
      wr_pos_r      <= 8'h01;
      poll_cnt_r    <= 8'h00;
      resync_pend_r <= 1'b0;
      busy_r        <= 1'b0;
    end else begin
      // A pulse arriving in the same cycle the flag is consumed stays pending
      resync_pend_r <= resync_pend_r | resync;
      case (state_r)
        ST_IDLE: begin
          poll_cnt_r <= 8'h00;
          if (enable) begin
            state_r <= ST_RDPOS;
            busy_r  <= 1'b1;
          end else begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end
        end
        ST_RDPOS: begin
          if (grant_s) begin
            wr_pos_r      <= rebase_s;
            resync_pend_r <= resync;
            // Full when the next slot is the one currently playing
            if ((rebase_s != cdda_d_in) && src_valid) begin
              state_r <= ST_WR0;
            end else begin
              state_r    <= ST_WAIT;
              poll_cnt_r <= 8'h00;
            end
          end else begin
            state_r <= ST_RDPOS;
          end
        end
        ST_WR0: begin
          if (xfer_s) begin
            state_r <= ST_WR1;
          end else begin
            state_r <= ST_WR0;
          end
        end
        ST_WR1: begin
          if (xfer_s) begin
            state_r <= ST_WR2;
          end else begin
            state_r <= ST_WR1;
          end
        end
        ST_WR2: begin
          if (xfer_s) begin
            state_r <= ST_WR3;
          end else begin
            state_r <= ST_WR2;
          end
        end
        ST_WR3: begin
          if (xfer_s) begin
            state_r <= ST_PUBLISH;
          end else begin
            state_r <= ST_WR3;
          end
        end
        ST_PUBLISH: begin
          if (grant_s) begin
            wr_pos_r <= wr_pos_r + 8'd1;
            if (enable) begin
              state_r <= ST_RDPOS;
            end else begin
              state_r <= ST_IDLE;
              busy_r  <= 1'b0;
            end
          end else begin
            state_r <= ST_PUBLISH;
          end
        end
        ST_WAIT: begin
          if (!enable) begin
            state_r    <= ST_IDLE;
            busy_r     <= 1'b0;
            poll_cnt_r <= 8'h00;
          end else if (poll_cnt_r == POLL_LAST) begin
            state_r    <= ST_RDPOS;
            poll_cnt_r <= 8'h00;
          end else begin
            state_r    <= ST_WAIT;
            poll_cnt_r <= poll_cnt_r + 8'd1;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cdda_refill_dma.sv
// Directed bench for cdda_refill_dma: a position-register model on the
// downstream bus, an in-order byte source and a log of every downstream write.
module tb_cdda_refill_dma;
  import cdda_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [10:0] cpu_a = 11'h000;
  logic [7:0]  cpu_d_in = 8'h00;
  logic [7:0]  cpu_d_out;
  logic        cpu_cs = 1'b0, cpu_oe = 1'b0, cpu_we = 1'b0;
  logic        cpu_wait;
  logic [10:0] cdda_a;
  logic [7:0]  cdda_d_out, cdda_d_in;
  logic        cdda_cs, cdda_oe, cdda_we;
  logic [7:0]  src_data;
  logic        src_valid, src_ready;
  logic        enable = 1'b0, resync = 1'b0;
  logic [7:0]  wr_pos;
  logic        busy;

  logic [7:0]  bufpos_m = 8'h00;
  logic [7:0]  src_mem [0:2047];
  int          src_idx = 0;
  int          src_avail = 0;
  logic [10:0] wlog_a [0:4095];
  logic [7:0]  wlog_d [0:4095];
  int          wlog_n = 0;
  int          cyc = 0;
  int          errors = 0;
  int          checks = 0;

  cdda_refill_dma #(.POLL_INTERVAL(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_a(cpu_a), .cpu_d_in(cpu_d_in), .cpu_d_out(cpu_d_out),
    .cpu_cs(cpu_cs), .cpu_oe(cpu_oe), .cpu_we(cpu_we), .cpu_wait(cpu_wait),
    .cdda_a(cdda_a), .cdda_d_out(cdda_d_out), .cdda_d_in(cdda_d_in),
    .cdda_cs(cdda_cs), .cdda_oe(cdda_oe), .cdda_we(cdda_we),
    .src_data(src_data), .src_valid(src_valid), .src_ready(src_ready),
    .enable(enable), .resync(resync), .wr_pos(wr_pos), .busy(busy)
  );

  always #5 clk = ~clk;

  // Downstream model: position register returns bufpos_m, everything else A5
  assign cdda_d_in = (cdda_a == 11'h001) ? bufpos_m : 8'hA5;
  assign src_valid = (src_idx < src_avail);
  assign src_data  = src_mem[src_idx[10:0]];

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (src_valid && src_ready) src_idx <= src_idx + 1;
  end

  always @(posedge clk) begin
    if (cdda_cs && cdda_we) begin
      wlog_a[wlog_n[11:0]] <= cdda_a;
      wlog_d[wlog_n[11:0]] <= cdda_d_out;
      wlog_n <= wlog_n + 1;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1);
  end

  function automatic logic [7:0] sb(input int i);
    return src_mem[i[10:0]];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_log(input string tag, input int idx, input logic [10:0] a, input logic [7:0] d);
    chk({tag, "_addr"}, {21'd0, wlog_a[idx[11:0]]}, {21'd0, a});
    chk({tag, "_data"}, {24'd0, wlog_d[idx[11:0]]}, {24'd0, d});
  endtask

  // Four byte writes of one frame followed by its last-valid publish
  task automatic chk_frame(input string tag, input int lb, input logic [7:0] slot, input int b);
    chk_log({tag, "_llo"}, lb,     {1'b1, slot, 2'b01}, sb(b));
    chk_log({tag, "_lhi"}, lb + 1, {1'b1, slot, 2'b00}, sb(b + 1));
    chk_log({tag, "_rlo"}, lb + 2, {1'b1, slot, 2'b11}, sb(b + 2));
    chk_log({tag, "_rhi"}, lb + 3, {1'b1, slot, 2'b10}, sb(b + 3));
    chk_log({tag, "_lvd"}, lb + 4, 11'h002, slot);
  endtask

  task automatic wait_wr(input string tag, input logic [7:0] target, input int limit);
    int n;
    n = 0;
    while (wr_pos !== target && n < limit) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_wrpos"}, {24'd0, wr_pos}, {24'd0, target});
  endtask

  task automatic go_idle(input string tag);
    int n;
    enable = 1'b0;
    n = 0;
    while (busy !== 1'b0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_idle"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int lb, b, t0, quiet;
    for (int i = 0; i < 2048; i++) src_mem[i] = 8'(i * 7 + 3);

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_src_ready", {31'd0, src_ready}, 32'd0);
    chk("rst_wr_pos", {24'd0, wr_pos}, 32'h01);
    chk("rst_cdda_cs", {29'd0, cdda_cs, cdda_oe, cdda_we}, 32'd0);
    chk("rst_cdda_a", {21'd0, cdda_a}, 32'd0);
    chk("rst_cdda_d", {24'd0, cdda_d_out}, 32'd0);
    chk("rst_cpu_wait", {31'd0, cpu_wait}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Two back-to-back frames into slots 1 and 2, six cycles each
    lb = wlog_n; b = src_idx;
    src_avail += 8;
    enable = 1'b1;
    t0 = cyc;
    wait_wr("s1", 8'h03, 40);
    chk("s1_cycles", cyc - t0, 32'd13);
    chk_frame("s1_f1", lb, 8'h01, b);
    chk_frame("s1_f2", lb + 5, 8'h02, b + 4);
    go_idle("s1");

    // CPU holds the bus for three cycles while the FSM sits in WR1
    lb = wlog_n; b = src_idx;
    src_avail += 4;
    enable = 1'b1;
    t0 = cyc;
    repeat (3) @(negedge clk);
    cpu_cs = 1'b1; cpu_oe = 1'b1; cpu_a = 11'h003;
    #1;
    chk("s2_rd_addr", {21'd0, cdda_a}, 32'h003);
    chk("s2_rd_strobes", {29'd0, cdda_cs, cdda_oe, cdda_we}, 32'b110);
    chk("s2_src_ready", {31'd0, src_ready}, 32'd0);
    chk("s2_cpu_rdata", {24'd0, cpu_d_out}, 32'hA5);
    @(negedge clk);
    cpu_oe = 1'b0; cpu_we = 1'b1; cpu_d_in = 8'h5A;
    #1;
    chk("s2_wr_strobes", {29'd0, cdda_cs, cdda_oe, cdda_we}, 32'b101);
    chk("s2_wr_data", {24'd0, cdda_d_out}, 32'h5A);
    @(negedge clk);
    cpu_we = 1'b0; cpu_oe = 1'b1; cpu_a = 11'h001; bufpos_m = 8'h00;
    #1;
    chk("s2_pos_rdata", {24'd0, cpu_d_out}, 32'h00);
    @(negedge clk);
    cpu_cs = 1'b0; cpu_oe = 1'b0; cpu_a = 11'h000; cpu_d_in = 8'h00;
    wait_wr("s2", 8'h04, 40);
    chk("s2_cycles", cyc - t0, 32'd10);
    chk_log("s2_llo", lb, 11'h40D, sb(b));
    chk_log("s2_cpu", lb + 1, 11'h003, 8'h5A);
    chk_log("s2_lhi", lb + 2, 11'h40C, sb(b + 1));
    chk_log("s2_rlo", lb + 3, 11'h40F, sb(b + 2));
    chk_log("s2_rhi", lb + 4, 11'h40E, sb(b + 3));
    chk_log("s2_lvd", lb + 5, 11'h002, 8'h03);
    go_idle("s2");

    // Source stalls after two bytes; enable drops mid-frame
    lb = wlog_n; b = src_idx;
    src_avail += 2;
    enable = 1'b1;
    repeat (4) @(negedge clk);
    enable = 1'b0;
    repeat (10) @(negedge clk);
    #1;
    chk("s4_hold_busy", {31'd0, busy}, 32'd1);
    chk("s4_hold_ready", {31'd0, src_ready}, 32'd1);
    chk("s4_hold_we", {31'd0, cdda_we}, 32'd0);
    chk("s4_hold_addr", {21'd0, cdda_a}, 32'h413);
    chk("s4_hold_nlog", wlog_n - lb, 32'd2);
    src_avail += 2;
    wait_wr("s4", 8'h05, 40);
    chk("s4_done_idle", {31'd0, busy}, 32'd0);
    chk_frame("s4_f", lb, 8'h04, b);
    go_idle("s4");

    // Buffer full: 16 quiet WAIT cycles, re-poll, then one frame into slot 5
    bufpos_m = 8'h05;
    lb = wlog_n; b = src_idx;
    src_avail += 4;
    enable = 1'b1;
    repeat (2) @(negedge clk);
    quiet = 0;
    for (int i = 0; i < 16; i++) begin
      if (cdda_cs === 1'b0 && busy === 1'b1) quiet++;
      @(negedge clk);
    end
    chk("s3_wait_cycles", quiet, 32'd16);
    chk("s3_repoll", {20'd0, cdda_oe, cdda_a}, {20'd0, 1'b1, 11'h001});
    chk("s3_no_write", wlog_n - lb, 32'd0);
    bufpos_m = 8'h06;
    wait_wr("s3", 8'h06, 40);
    chk_frame("s3_f", lb, 8'h05, b);
    go_idle("s3");

    // Fill up to slot 255, then wrap through slot 0
    bufpos_m = 8'h03;
    src_avail += 249 * 4;
    enable = 1'b1;
    wait_wr("s5_fill", 8'hFF, 2000);
    go_idle("s5a");
    lb = wlog_n; b = src_idx;
    src_avail += 8;
    enable = 1'b1;
    wait_wr("s5_wrap", 8'h01, 40);
    chk_frame("s5_ff", lb, 8'hFF, b);
    chk_frame("s5_00", lb + 5, 8'h00, b + 4);
    go_idle("s5b");

    // Resync rebases onto the polled position + 1
    bufpos_m = 8'h40;
    resync = 1'b1;
    @(negedge clk);
    resync = 1'b0;
    lb = wlog_n; b = src_idx;
    src_avail += 4;
    enable = 1'b1;
    wait_wr("s6", 8'h42, 40);
    chk_frame("s6_f", lb, 8'h41, b);
    go_idle("s6");

    // Reset in the middle of a frame abandons it
    lb = wlog_n;
    src_avail += 2;
    enable = 1'b1;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    enable = 1'b0;
    #1;
    chk("s7_wr_pos", {24'd0, wr_pos}, 32'h01);
    chk("s7_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("s7_nlog", wlog_n - lb, 32'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
